// File: rtl/ps_window_linebuffer.sv
// ps_window_linebuffer
//   Line-length pixel FIFO that returns a TAPS-wide horizontal window on every
//   accepted read. It tracks occupancy, drives full/empty/ready flags, and
//   marks the read of the last pixel of a line with o_line_done. Each buffered
//   line in the capture -> kernel path uses one instance.
//
//   Window taps that fall beyond the end of the line never wrap into the next
//   line. Instead they take an edge value:
//     PS_LINEBUFFER_ZERO_PAD_EN defined   : out-of-line taps are 0
//     PS_LINEBUFFER_ZERO_PAD_EN undefined : out-of-line taps repeat the last
//                                           pixel of the line
//
//   Pipeline: p0 is the combinational window at rptr. p1 is the registered
//   window, valid and line-done (one cycle after the accepted read).

module ps_window_linebuffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_LENGTH = 640,
  parameter int TAPS        = 3,
  localparam int CW         = $clog2(LINE_LENGTH + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_clear,
  input  logic                       i_wr,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  output logic                       o_full,
  input  logic                       i_rd,
  output logic                       o_rd_ready,
  output logic [TAPS*DATA_WIDTH-1:0] o_rdata,
  output logic                       o_rvalid,
  output logic                       o_line_done,
  output logic                       o_empty,
  output logic [CW-1:0]              o_count
);

  localparam int PW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int IW = CW + 1;

  logic [DATA_WIDTH-1:0]      mem [LINE_LENGTH];
  logic [PW-1:0]              wptr;
  logic [PW-1:0]              rptr;
  logic [CW-1:0]              count;
  logic [CW-1:0]              remain;
  logic [CW-1:0]              need;
  logic                       wr_ok;
  logic                       rd_ok;
  logic [DATA_WIDTH-1:0]      edge_pix;
  logic [TAPS*DATA_WIDTH-1:0] win_p0;
  logic [TAPS*DATA_WIDTH-1:0] rdata_p1;
  logic                       vld_p1;
  logic                       line_done_p1;

  // Pointer advance with wrap at the end of the line.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(LINE_LENGTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Flags come from the registered count only.
  assign o_full  = (count == CW'(LINE_LENGTH));
  assign o_empty = (count == '0);
  assign o_count = count;

  // Near the end of the line a "full window" is only the pixels left in the line.
  assign remain     = CW'(LINE_LENGTH) - CW'(rptr);
  assign need       = (remain < CW'(TAPS)) ? remain : CW'(TAPS);
  assign o_rd_ready = (count >= need);

  // Clear wins over both requests. A write while full is dropped even when a read pops.
  assign wr_ok = i_wr && !o_full && !i_clear;
  assign rd_ok = i_rd && o_rd_ready && !i_clear;

`ifdef PS_LINEBUFFER_ZERO_PAD_EN
  assign edge_pix = '0;
`else
  assign edge_pix = mem[LINE_LENGTH-1];
`endif

  // Pixel storage write port (contents survive reset and clear).
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr] <= i_wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (i_clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= ptr_inc(wptr);
      if (rd_ok) rptr <= ptr_inc(rptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- p0: window assembly at rptr, tap0 in the MSBs ----
  // Build the window from rptr, replacing taps past the line end with the edge value.
  always_comb begin
    logic [IW-1:0] idx;
    win_p0 = '0;
    idx    = '0;
    for (int k = 0; k < TAPS; k++) begin
      idx = IW'(rptr) + IW'(k);
      if (idx < IW'(LINE_LENGTH))
        win_p0[(TAPS-1-k)*DATA_WIDTH +: DATA_WIDTH] = mem[idx[PW-1:0]];
      else
        win_p0[(TAPS-1-k)*DATA_WIDTH +: DATA_WIDTH] = edge_pix;
    end
  end

  // ---- p1: registered window, valid and end-of-line marker ----
  // Register the window on an accepted read. The data holds between reads.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rdata_p1     <= '0;
      vld_p1       <= 1'b0;
      line_done_p1 <= 1'b0;
    end else begin
      vld_p1       <= rd_ok;
      line_done_p1 <= rd_ok && (rptr == PW'(LINE_LENGTH - 1));
      if (rd_ok) rdata_p1 <= win_p0;
    end
  end

  assign o_rdata     = rdata_p1;
  assign o_rvalid    = vld_p1;
  assign o_line_done = line_done_p1;

endmodule

// File: tb/tb_ps_window_linebuffer.sv
// Directed table-driven bench for ps_window_linebuffer (LINE_LENGTH=8, TAPS=3).
// Expected windows follow PS_LINEBUFFER_ZERO_PAD_EN when it is defined.

module tb_ps_window_linebuffer;

  localparam int DW = 8;
  localparam int LL = 8;
  localparam int TP = 3;
  localparam int CW = $clog2(LL + 1);

`ifdef PS_LINEBUFFER_ZERO_PAD_EN
  localparam logic [7:0] E = 8'h00;
`else
  localparam logic [7:0] E = 8'h17;
`endif

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic            i_clear = 1'b0;
  logic            i_wr = 1'b0;
  logic [DW-1:0]   i_wdata = '0;
  logic            i_rd = 1'b0;
  logic            o_full;
  logic            o_rd_ready;
  logic [TP*DW-1:0] o_rdata;
  logic            o_rvalid;
  logic            o_line_done;
  logic            o_empty;
  logic [CW-1:0]   o_count;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  ps_window_linebuffer #(.DATA_WIDTH(DW), .LINE_LENGTH(LL), .TAPS(TP)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clear(i_clear),
    .i_wr(i_wr), .i_wdata(i_wdata), .o_full(o_full),
    .i_rd(i_rd), .o_rd_ready(o_rd_ready), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_line_done(o_line_done),
    .o_empty(o_empty), .o_count(o_count)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  wdata;
    logic        rd;
    logic        clr;
    logic        vld;
    logic [23:0] rdata;
    logic        done;
    logic [3:0]  cnt;
    logic        empty;
    logic        full;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic wr, input logic [7:0] wd, input logic rd, input logic clr,
                     input logic vld, input logic [23:0] rdata, input logic done,
                     input logic [3:0] cnt, input logic empty, input logic full, input logic rdy);
    vec_t v;
    v.wr = wr; v.wdata = wd; v.rd = rd; v.clr = clr; v.vld = vld; v.rdata = rdata;
    v.done = done; v.cnt = cnt; v.empty = empty; v.full = full; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".rvalid"}, 32'(o_rvalid), 32'(v.vld));
    chk({tag, ".rdata"}, 32'(o_rdata), 32'(v.rdata));
    chk({tag, ".line_done"}, 32'(o_line_done), 32'(v.done));
    chk({tag, ".count"}, 32'(o_count), 32'(v.cnt));
    chk({tag, ".empty"}, 32'(o_empty), 32'(v.empty));
    chk({tag, ".full"}, 32'(o_full), 32'(v.full));
    chk({tag, ".rd_ready"}, 32'(o_rd_ready), 32'(v.rdy));
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge i_clk);
    i_wr = v.wr; i_wdata = v.wdata; i_rd = v.rd; i_clear = v.clr;
    @(posedge i_clk);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    logic [23:0] win;
    logic [7:0]  t [3];
    vec_t        v;

    // Reset state while i_rstn is low.
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.count", 32'(o_count), 32'd0);
    chk("rst.empty", 32'(o_empty), 32'd1);
    chk("rst.full", 32'(o_full), 32'd0);
    chk("rst.rd_ready", 32'(o_rd_ready), 32'd0);
    chk("rst.rvalid", 32'(o_rvalid), 32'd0);
    chk("rst.rdata", 32'(o_rdata), 32'd0);
    chk("rst.line_done", 32'(o_line_done), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Line fill 0x10..0x17.
    for (int k = 1; k <= 8; k++)
      add(1, 8'(8'h0F + k), 0, 0, 0, 24'h0, 0, 4'(k), 0, (k == 8), (k >= 3));
    // Drain the whole line. The last two windows hit the line edge.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 3; k++) t[k] = (r + k <= 7) ? 8'(8'h10 + r + k) : E;
      win = {t[0], t[1], t[2]};
      add(0, 8'h00, 1, 0, 1, win, (r == 7), 4'(7 - r), (r == 7), 0, (r != 7));
    end
    // Idle: rvalid drops and rdata holds.
    add(0, 8'h00, 0, 0, 0, {8'h17, E, E}, 0, 4'd0, 1, 0, 0);
    // Overfill: 9 writes, the 9th is dropped.
    for (int k = 1; k <= 9; k++)
      add(1, 8'(k - 1), 0, 0, 0, {8'h17, E, E}, 0, 4'((k > 8) ? 8 : k), 0, (k >= 8), (k >= 3));
    // Read and write while full: read pops, write dropped.
    add(1, 8'hEE, 1, 0, 1, {8'h00, 8'h01, 8'h02}, 0, 4'd7, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, {8'h01, 8'h02, 8'h03}, 0, 4'd6, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, {8'h02, 8'h03, 8'h04}, 0, 4'd5, 0, 0, 1);
    // Clear with rd and wr asserted at count 5.
    add(1, 8'hAA, 1, 1, 0, {8'h02, 8'h03, 8'h04}, 0, 4'd0, 1, 0, 0);
    add(1, 8'h5A, 0, 0, 0, {8'h02, 8'h03, 8'h04}, 0, 4'd1, 0, 0, 0);
    add(1, 8'h5B, 0, 0, 0, {8'h02, 8'h03, 8'h04}, 0, 4'd2, 0, 0, 0);
    // Read with only 2 pixels stored is ignored.
    add(0, 8'h00, 1, 0, 0, {8'h02, 8'h03, 8'h04}, 0, 4'd2, 0, 0, 0);
    add(1, 8'h5C, 0, 0, 0, {8'h02, 8'h03, 8'h04}, 0, 4'd3, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, {8'h5A, 8'h5B, 8'h5C}, 0, 4'd2, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Async reset during a read burst.
    v = '{1, 8'h60, 0, 0, 0, {8'h5A, 8'h5B, 8'h5C}, 0, 4'd3, 0, 0, 1};
    apply("burst.w60", v);
    v = '{1, 8'h61, 0, 0, 0, {8'h5A, 8'h5B, 8'h5C}, 0, 4'd4, 0, 0, 1};
    apply("burst.w61", v);
    v = '{1, 8'h62, 0, 0, 0, {8'h5A, 8'h5B, 8'h5C}, 0, 4'd5, 0, 0, 1};
    apply("burst.w62", v);
    v = '{0, 8'h00, 1, 0, 1, {8'h5B, 8'h5C, 8'h60}, 0, 4'd4, 0, 0, 1};
    apply("burst.rd", v);
    #2 i_rstn = 1'b0;
    #1;
    chk("arst.rvalid", 32'(o_rvalid), 32'd0);
    chk("arst.count", 32'(o_count), 32'd0);
    chk("arst.rdata", 32'(o_rdata), 32'd0);
    chk("arst.empty", 32'(o_empty), 32'd1);
    chk("arst.rd_ready", 32'(o_rd_ready), 32'd0);
    @(negedge i_clk);
    i_rd = 1'b0;
    @(posedge i_clk);
    #1;
    chk("arst.hold_count", 32'(o_count), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Resume from address 0.
    v = '{1, 8'h71, 0, 0, 0, 24'h0, 0, 4'd1, 0, 0, 0};
    apply("post.w71", v);
    v = '{1, 8'h72, 0, 0, 0, 24'h0, 0, 4'd2, 0, 0, 0};
    apply("post.w72", v);
    v = '{1, 8'h73, 0, 0, 0, 24'h0, 0, 4'd3, 0, 0, 1};
    apply("post.w73", v);
    v = '{0, 8'h00, 1, 0, 1, {8'h71, 8'h72, 8'h73}, 0, 4'd2, 0, 0, 0};
    apply("post.rd", v);

    @(negedge i_clk);
    i_rd = 1'b0; i_wr = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps_window_linebuffer.md
Name: ps_window_linebuffer

Overview:
Parametrised successor to the single-line pixel buffer. It is a line-length FIFO that returns a TAPS-wide horizontal window per read, with occupancy tracking, flow-control flags and an end-of-line marker. It sits between the capture/greyscale stage and the kernel (Sobel/Gaussian) stages, one instance per buffered line. Pixel width, window width and line length are all generic.

Parameters:
DATA_WIDTH, 8, bits per pixel
LINE_LENGTH, 640, pixels per line and FIFO depth; must be at least TAPS
TAPS, 3, pixels per read window; odd and at least 1
CW (localparam), $clog2(LINE_LENGTH+1), width of o_count

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset; one clock; reset is asynchronous and active-low
i_clear  in  1  synchronous flush of pointers and count
i_wr  in  1  write request
i_wdata  in  DATA_WIDTH  write pixel
o_full  out  1  count == LINE_LENGTH
i_rd  in  1  read request (advance window by one pixel)
o_rd_ready  out  1  a full window is available at rptr
o_rdata  out  TAPS*DATA_WIDTH  window; tap0 (pixel at rptr) in MSBs
o_rvalid  out  1  o_rdata valid this cycle
o_line_done  out  1  pulse with the rvalid of the read at rptr = LINE_LENGTH-1
o_empty  out  1  count == 0
o_count  out  CW  pixels written and not yet consumed

Behaviour:
- Reset (async, i_rstn=0): wptr, rptr, count, o_rdata, o_rvalid and o_line_done all 0; o_empty=1, o_full=0, o_rd_ready=0. Memory is not reset.
- Write accepted: i_wr && !o_full. mem[wptr] <= i_wdata; wptr wraps LINE_LENGTH-1 -> 0. A write while full is dropped silently, even if a read occurs in the same cycle.
- need = min(TAPS, LINE_LENGTH - rptr). o_rd_ready = (count >= need), combinational from registered state.
- Read accepted: i_rd && o_rd_ready. rptr advances and wraps LINE_LENGTH-1 -> 0. A read while not ready is ignored: no rvalid and no pointer change.
- count: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither occur. o_full, o_empty and o_count are derived from the registered count.
- Window: tap k (k = 0..TAPS-1) = mem[rptr+k] when rptr+k <= LINE_LENGTH-1. Otherwise the edge value (see Optional Feature). Indices never wrap into the next line.
- Latency: o_rdata, o_rvalid and o_line_done are registered, 1 cycle after the accepted read. o_rvalid=0 on non-read cycles; o_rdata holds its last value.
- Simultaneous read/write on the same address is impossible by construction: the read only touches slots with count > 0.
- i_clear: zeroes wptr, rptr and count, and forces o_rvalid and o_line_done to 0 next cycle. It has priority over i_rd and i_wr in the same cycle; memory is unchanged.
- Reset asserted mid-read: the pending rvalid is lost and outputs go to reset values immediately, without waiting for a clock edge.

Optional Feature:
PS_LINEBUFFER_ZERO_PAD_EN.
- Defined: taps beyond the line end are 0.
- Undefined: taps beyond the line end replicate mem[LINE_LENGTH-1], i.e. the last pixel of the line.

Test Plan:
- LINE_LENGTH=8, TAPS=3, DATA_WIDTH=8; write 0x10..0x17, then read 8 times -> windows {10,11,12}, {11,12,13} ... {15,16,17}, {16,17,17}, {17,17,17}. o_line_done accompanies the 8th o_rvalid only. o_count returns to 0 and o_empty=1.
- Same stimulus with PS_LINEBUFFER_ZERO_PAD_EN defined -> rptr=6 gives {16,17,00}; rptr=7 gives {17,00,00}.
- Write 9 pixels 0x00..0x08 with no reads -> o_full=1 after the 8th, 9th dropped, o_count=8. Then i_rd+i_wr in one cycle -> read accepted, write dropped, o_count=7.
- From empty, write 2 pixels -> o_rd_ready=0 and i_rd produces no o_rvalid. The 3rd write sets o_rd_ready=1; the next read returns the 3 written pixels.
- With o_count=5, pulse i_clear while i_rd=i_wr=1 -> next cycle o_count=0, o_empty=1, o_rvalid=0. The following write lands at address 0 and is read back as tap0.
- Assert i_rstn low between clock edges during a read burst -> o_rvalid, o_count and o_rdata go to 0 before the next edge. After release, normal operation resumes from address 0.
